// File: rtl/sram_pin_pkg.sv
// Shared types and constants for the async-SRAM pin responder.
package sram_pin_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int ERR_NOLANE  = 0;
    localparam int ERR_ADDRCHG = 1;
    localparam int ERR_BDCOLL  = 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
endpackage

// File: rtl/sram_resp_mem.sv
// Dual-port word array: port A serves the pins (byte-lane write, gated read),
// port B is the backdoor with a write-first registered readback.
module sram_resp_mem
    import sram_pin_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] a_waddr,
    input  logic [1:0]            a_be,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [ADDR_WIDTH-1:0] a_raddr,
    input  logic                  a_re,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_we,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] b_next;

    // The parent never lets both ports write the same word on one edge.
    always_ff @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_wdata;
        if (a_be[1]) mem[a_waddr][15:8] <= a_wdata[15:8];
        if (a_be[0]) mem[a_waddr][7:0]  <= a_wdata[7:0];
        if (a_re) a_rdata <= mem[a_raddr];
    end

    always_comb begin
        b_next = mem[b_addr];
        if (b_we) b_next = b_wdata;
        if (a_be[1] && (a_waddr == b_addr)) b_next[15:8] = a_wdata[15:8];
        if (a_be[0] && (a_waddr == b_addr)) b_next[7:0]  = a_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) b_rdata <= '0;
        else       b_rdata <= b_next;
    end
endmodule

// File: rtl/sram_pin_responder.sv
// Async-SRAM pin responder: oversamples the pins, emulates end-of-WE commit,
// backs the bus with an on-chip array and exposes backdoor, counters, errors.
module sram_pin_responder
    import sram_pin_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [15:0]           SRAM_DQ,
    input  logic [17:0]           SRAM_ADDR,
    input  logic                  SRAM_UB_N,
    input  logic                  SRAM_LB_N,
    input  logic                  SRAM_WE_N,
    input  logic                  SRAM_CE_N,
    input  logic                  SRAM_OE_N,
    input  logic [ADDR_WIDTH-1:0] bd_addr,
    input  logic                  bd_we,
    input  logic [15:0]           bd_din,
    output logic [15:0]           bd_dout,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [2:0]            err,
    input  logic                  err_clr
);
    state_t                state, nxt;
    logic [DATA_WIDTH-1:0] s_dq;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_ub_n, s_lb_n, s_we_n, s_ce_n, s_oe_n;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [1:0]            wr_be;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  commit, pin_we, coll, rd_done, b_we, a_re;
    logic [1:0]            a_be, dq_oe;
    logic                  unused_addr;

    assign unused_addr = ^SRAM_ADDR[17:ADDR_WIDTH];

    // Pin sampling is free-running so the FSM re-enters from live pins after reset.
    always_ff @(posedge clk) begin
        s_dq   <= SRAM_DQ;
        s_addr <= SRAM_ADDR[ADDR_WIDTH-1:0];
        s_ub_n <= SRAM_UB_N;
        s_lb_n <= SRAM_LB_N;
        s_we_n <= SRAM_WE_N;
        s_ce_n <= SRAM_CE_N;
        s_oe_n <= SRAM_OE_N;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        if (!s_ce_n && !s_we_n)      nxt = WRITE;
        else if (!s_ce_n && !s_oe_n) nxt = READ;
        commit  = (state == WRITE) && (nxt != WRITE) && !reset;
        pin_we  = commit && (wr_be != 2'b00);
        a_be    = pin_we ? wr_be : 2'b00;
        coll    = pin_we && bd_we && (bd_addr == wr_addr);
        b_we    = bd_we && !coll;
        rd_done = (state == READ) && (nxt != READ) && !reset;
        a_re    = (nxt == READ) && !reset;
        dq_oe   = (state == READ) ? {~s_ub_n, ~s_lb_n} : 2'b00;
    end

    // Last sampled value during the WE pulse wins.
    always_ff @(posedge clk) begin
        if (!reset && nxt == WRITE) begin
            wr_addr <= s_addr;
            wr_data <= s_dq;
            wr_be   <= {~s_ub_n, ~s_lb_n};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
            err      <= '0;
        end else begin
            if (err_clr) err <= '0;
            if (commit && wr_be == 2'b00) err[ERR_NOLANE] <= 1'b1;
            if (state == WRITE && nxt == WRITE && s_addr != wr_addr) err[ERR_ADDRCHG] <= 1'b1;
            if (coll) err[ERR_BDCOLL] <= 1'b1;
            if (pin_we && wr_count != '1) wr_count <= wr_count + 1'b1;
            if (rd_done && rd_count != '1) rd_count <= rd_count + 1'b1;
        end
    end

    sram_resp_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .a_waddr (wr_addr),
        .a_be    (a_be),
        .a_wdata (wr_data),
        .a_raddr (s_addr),
        .a_re    (a_re),
        .a_rdata (rd_q),
        .b_addr  (bd_addr),
        .b_we    (b_we),
        .b_wdata (bd_din),
        .b_rdata (bd_dout)
    );

    assign SRAM_DQ[15:8] = dq_oe[1] ? rd_q[15:8] : 8'bz;
    assign SRAM_DQ[7:0]  = dq_oe[0] ? rd_q[7:0]  : 8'bz;
endmodule

// File: tb/tb_sram_pin_responder.sv
// Directed scoreboard bench for sram_pin_responder.
module tb_sram_pin_responder;
    logic        clk = 1'b0;
    logic        reset;
    wire  [15:0] dq;
    logic [15:0] tb_dq;
    logic        tb_drv;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic [8:0]  bd_addr;
    logic        bd_we;
    logic [15:0] bd_din, bd_dout, rd_count, wr_count;
    logic [2:0]  err;
    logic        err_clr;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    assign dq = tb_drv ? tb_dq : 16'hzzzz;

    sram_pin_responder #(.ADDR_WIDTH(9), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .SRAM_DQ(dq), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .bd_addr(bd_addr), .bd_we(bd_we), .bd_din(bd_din), .bd_dout(bd_dout),
        .rd_count(rd_count), .wr_count(wr_count), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expv(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_pins(input logic ce, input logic we, input logic oe,
                            input logic ub, input logic lb, input logic [17:0] a);
        ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb; addr = a;
    endtask

    task automatic pins_idle();
        set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr);
        tb_drv = 1'b0;
    endtask

    task automatic preload(input logic [8:0] a, input logic [15:0] d);
        bd_addr = a; bd_din = d; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tb_dq = '0; tb_drv = 1'b0; addr = '0;
        bd_addr = '0; bd_we = 1'b0; bd_din = '0; err_clr = 1'b0;
        pins_idle();
        repeat (3) tick();

        // reset state
        expv("rst_rd_count", 16'd0); chk(rd_count);
        expv("rst_wr_count", 16'd0); chk(wr_count);
        expv("rst_err", 16'd0);      chk(err);
        expv("rst_bd_dout", 16'd0);  chk(bd_dout);
        expv("rst_dq_oe", 16'd0);    chk(dut.dq_oe);
        reset = 1'b0;
        tick();

        preload(9'h012, 16'hBEEF);
        preload(9'h020, 16'hAAAA);
        preload(9'h030, 16'h0C0C);
        preload(9'h031, 16'h0000);
        preload(9'h040, 16'h0000);
        preload(9'h050, 16'h0101);
        tick();

        // read 0x012, both lanes
        set_pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00012);
        tick();
        expv("rd_oe_edge1", 16'd0); chk(dut.dq_oe);
        tick();
        expv("rd_oe_edge2", 16'h3); chk(dut.dq_oe);
        expv("rd_dq_edge2", 16'hBEEF); chk(dq);
        tick(); tick();
        expv("rd_dq_edge4", 16'hBEEF); chk(dq);
        pins_idle();
        tick();
        expv("rd_count_hold", 16'd0); chk(rd_count);
        tick();
        expv("rd_count_done", 16'd1); chk(rd_count);
        expv("rd_oe_off", 16'd0); chk(dut.dq_oe);

        // lower-lane write over 0xAAAA
        bd_addr = 9'h020;
        set_pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'h00020);
        tb_dq = 16'h1234; tb_drv = 1'b1;
        repeat (3) tick();
        pins_idle();
        tick();
        expv("wr1_count_pre", 16'd0); chk(wr_count);
        tick();
        expv("wr1_bd_dout", 16'hAA34); chk(bd_dout);
        expv("wr1_count", 16'd1); chk(wr_count);
        expv("wr1_err", 16'd0); chk(err);

        // data changes on the last low cycle; OE low too (WE dominates)
        set_pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00040);
        tb_dq = 16'h1111; tb_drv = 1'b1;
        tick(); tick();
        expv("wr2_no_drive", 16'd0); chk(dut.dq_oe);
        tb_dq = 16'h2222;
        tick();
        pins_idle();
        tick();
        bd_addr = 9'h060; bd_din = 16'h6060; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
        expv("wr2_bd_other", 16'h6060); chk(bd_dout);
        expv("wr2_err", 16'd0); chk(err);
        expv("wr2_count", 16'd2); chk(wr_count);
        bd_addr = 9'h040;
        tick();
        expv("wr2_last_wins", 16'h2222); chk(bd_dout);

        // no lane selected
        bd_addr = 9'h020;
        set_pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'h00020);
        tb_dq = 16'hFFFF; tb_drv = 1'b1;
        tick(); tick();
        pins_idle();
        tick(); tick();
        expv("nolane_err", 16'h1); chk(err);
        expv("nolane_count", 16'd2); chk(wr_count);
        expv("nolane_mem", 16'hAA34); chk(bd_dout);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        expv("err_clr", 16'd0); chk(err);

        // address change mid-pulse plus colliding backdoor write
        set_pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00030);
        tb_dq = 16'h5555; tb_drv = 1'b1;
        tick(); tick();
        addr = 18'h00031;
        tick();
        pins_idle();
        tick();
        expv("addrchg_err", 16'h2); chk(err);
        bd_addr = 9'h031; bd_din = 16'h9999; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
        expv("coll_err", 16'h6); chk(err);
        expv("coll_pin_wins", 16'h5555); chk(bd_dout);
        expv("coll_count", 16'd3); chk(wr_count);
        bd_addr = 9'h030;
        tick();
        expv("addrchg_old_addr", 16'h0C0C); chk(bd_dout);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // reset during a write pulse
        set_pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00050);
        tb_dq = 16'h7777; tb_drv = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        pins_idle();
        tick();
        expv("rstw_dq_oe", 16'd0); chk(dut.dq_oe);
        tick();
        reset = 1'b0;
        bd_addr = 9'h050;
        tick();
        expv("rstw_no_commit", 16'h0101); chk(bd_dout);
        expv("rstw_wr_count", 16'd0); chk(wr_count);
        expv("rstw_rd_count", 16'd0); chk(rd_count);
        expv("rstw_err", 16'd0); chk(err);
        bd_addr = 9'h020;
        tick();
        expv("rstw_keep_020", 16'hAA34); chk(bd_dout);
        bd_addr = 9'h031;
        tick();
        expv("rstw_keep_031", 16'h5555); chk(bd_dout);

        // lower-lane read after reset, aliased upper address bits
        set_pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h3FE31);
        tick(); tick();
        expv("rd_lo_oe", 16'h1); chk(dut.dq_oe);
        expv("rd_lo_dq", 16'h0055); chk({8'h00, dq[7:0]});
        pins_idle();
        tick(); tick();
        expv("rd_lo_count", 16'd1); chk(rd_count);
        expv("rstw_wr_still0", 16'd0); chk(wr_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_pin_responder.md
Name: sram_pin_responder

Overview:
- Synthesizable responder for the async-SRAM pin protocol (DQ/ADDR/UB_N/LB_N/WE_N/CE_N/OE_N) driven by the openMSP430 external SRAM bridge.
- Backs the pins with an on-chip word array so the bridge can be exercised on boards without external SRAM, or looped back in simulation.
- Samples the pins with an oversampling clock (clk ≥ 4× the initiator access rate) and emulates end-of-WE-pulse write semantics.
- Provides a backdoor port for preload/readback, plus status counters and error flags.

Parameters:
- ADDR_WIDTH, 9, word address bits used from SRAM_ADDR; array depth is 2**ADDR_WIDTH words of 16 bits.
- CNT_WIDTH, 16, width of the read and write cycle counters.

Ports:
- clk  in  1  oversampling clock, single clock domain.
- reset  in  1  synchronous, active-high.
- SRAM_DQ  inout  16  data bus; driven per byte lane only during a read.
- SRAM_ADDR  in  18  word address; bits above ADDR_WIDTH-1 ignored (aliasing).
- SRAM_UB_N  in  1  upper byte lane select, active low.
- SRAM_LB_N  in  1  lower byte lane select, active low.
- SRAM_WE_N  in  1  write enable, active low.
- SRAM_CE_N  in  1  chip enable, active low.
- SRAM_OE_N  in  1  output enable, active low.
- bd_addr  in  ADDR_WIDTH  backdoor word address.
- bd_we  in  1  backdoor full-word write strobe.
- bd_din  in  16  backdoor write data.
- bd_dout  out  16  backdoor read data, mem[bd_addr] registered (1 cycle).
- rd_count  out  CNT_WIDTH  completed read cycles, saturating.
- wr_count  out  CNT_WIDTH  committed write cycles, saturating.
- err  out  3  sticky errors: [0] write with no lane selected, [1] address changed while WE_N low, [2] backdoor write dropped by collision.
- err_clr  in  1  clears err (set conditions in the same cycle win).

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high, named reset.
- Pin sampling: all pin inputs, including SRAM_DQ, are registered every posedge (the s_* stage). All decode uses the s_* values only.
- States: IDLE, READ, WRITE. Each transition is evaluated from s_* values at the posedge.
  - WRITE: entered or held when s_ce_n=0 and s_we_n=0. WE dominates OE (OE ignored while WE is low).
  - READ: s_ce_n=0, s_we_n=1, s_oe_n=0.
  - IDLE: all other combinations.
- WRITE capture: every cycle in WRITE, wr_addr, wr_data and the lane enables are loaded from s_*; the last value wins.
  - If s_addr differs from the held wr_addr while in WRITE, set err[1].
- WRITE commit: on the first edge that leaves WRITE, update the enabled byte lanes of mem[wr_addr] and increment wr_count.
  - If no lane was enabled, nothing is written, err[0] is set, and wr_count is unchanged.
- READ: rd_q <= mem[s_addr] every cycle in READ. SRAM_DQ[15:8] is driven with rd_q[15:8] when state=READ and s_ub_n=0; [7:0] likewise with s_lb_n. Otherwise the lane is high-Z.
  - Data is valid on DQ two edges after the pins change.
  - rd_count increments once, on the READ→non-READ transition.
- Leaving READ: outputs tri-state on the edge that leaves READ. DQ is never driven in IDLE or WRITE.
- Backdoor:
  - bd_we writes the full word.
  - If a pin commit occurs on the same edge to the same address, the pin commit wins, the backdoor write is dropped, and err[2] is set.
  - Different addresses both write.
  - bd_dout reflects the array after any same-edge write (write-first).
- Counters: saturate at all-ones.
- Reset values:
  - State IDLE, DQ fully high-Z, pending write discarded (no commit).
  - rd_count=0, wr_count=0, err=0, bd_dout=0.
  - Array contents preserved.
- Reset mid-operation: a WRITE in progress is aborted. After reset the responder re-enters from the sampled pins on the next edge.

Decomposition:
- Shared package sram_pin_pkg: state enum (IDLE, READ, WRITE), error bit indices (ERR_NOLANE=0, ERR_ADDRCHG=1, ERR_BDCOLL=2), DATA_WIDTH=16.
- One sub-module: sram_resp_mem, a dual-port word array with byte-lane write enables.
  - Port A: pin commit and read.
  - Port B: backdoor.
  - Collision arbitration lives in the parent.

Test Plan:
- Backdoor preload mem[0x012]=0xBEEF; pins CE_N=0, OE_N=0, UB_N=LB_N=0, ADDR=0x012 for 4 clk → DQ=0xBEEF from the second edge; rd_count=1 after CE_N rises.
- Write ADDR=0x020, DQ=0x1234, LB_N=0, UB_N=1, WE_N low 3 clk over an old value 0xAAAA → after WE_N rises, bd_dout=0xAA34, wr_count=1, err=0.
- Write with DQ changing 0x1111→0x2222 on the last low cycle of WE_N → committed value 0x2222 (last sampled wins).
- WE_N low with UB_N=LB_N=1 → no array change, err[0]=1, wr_count unchanged; err_clr → err=0.
- Address change 0x030→0x031 mid-pulse → err[1]=1, data committed at 0x031; same-edge bd_we to 0x031 → err[2]=1, pin data retained.
- Assert reset during a WRITE pulse → no commit, counters 0, DQ high-Z, previously written words still readable via backdoor.
